// File: rtl/pfb_pkg.sv
// pfb_pkg: shared widths, FSM states and queue entry type for the instruction prefetch buffer
package pfb_pkg;
    localparam int INST_W = 16;
    localparam int PC_W   = 16;
    typedef enum logic [1:0] {S_FETCH, S_FULL, S_REDIR} state_t;
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } entry_t;
endpackage

// File: rtl/pfb_fifo.sv
// pfb_fifo: circular instruction queue with synchronous flush; head reads zero while empty
module pfb_fifo
    import pfb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  entry_t                 din,
    output entry_t                 head,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    entry_t mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic do_pop;
    assign valid  = count != '0;
    assign do_pop = pop & valid;
    assign head   = valid ? mem[rd] : '0;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr] <= din;
                wr      <= wr + AW'(1);
            end
            if (do_pop) rd <= rd + AW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/imem_prefetch_buf.sv
// imem_prefetch_buf: imem fetch stage feeding the IR through a credit-limited prefetch queue.
// Define IMEM_PREFETCH_BYPASS_EN to forward a live return straight to the IR when the queue is empty.
module imem_prefetch_buf
    import pfb_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   redirect_valid,
    input  logic [PC_W-1:0]        redirect_pc,
    output logic [PC_W-1:0]        imem_addr,
    output logic                   imem_rd,
    input  logic [INST_W-1:0]      imem_data,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [INST_W-1:0]      inst,
    output logic [PC_W-1:0]        inst_pc,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int CW = $clog2(DEPTH) + 1;
    state_t state;
    logic [PC_W-1:0] fetch_pc, tag;
    logic inflight, live, credit, push, pop, q_valid;
    entry_t head, din;
    assign credit    = ({1'b0, occupancy} + {{CW{1'b0}}, inflight}) < (CW+1)'(DEPTH);
    assign imem_rd   = ~resetn & ~redirect_valid & (state == S_FETCH) & credit;
    assign imem_addr = fetch_pc;
    // a word landing in a redirect cycle belongs to the abandoned stream
    assign live      = inflight & ~redirect_valid;
    assign pop       = q_valid & inst_ready;
    assign din       = '{inst: imem_data, pc: tag};
`ifdef IMEM_PREFETCH_BYPASS_EN
    logic byp;
    assign byp        = live & ~q_valid;
    assign push       = live & ~(byp & inst_ready);
    assign inst_valid = q_valid | byp;
    assign inst       = q_valid ? head.inst : byp ? imem_data : '0;
    assign inst_pc    = q_valid ? head.pc : byp ? tag : '0;
`else
    assign push       = live;
    assign inst_valid = q_valid;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;
`endif
    pfb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (resetn),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .valid (q_valid),
        .count (occupancy)
    );
    always_ff @(posedge clk) begin
        if (resetn) begin
            state    <= S_FETCH;
            fetch_pc <= RESET_PC;
            tag      <= '0;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            state    <= S_REDIR;
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            state    <= state == S_REDIR ? S_FETCH :
                        state == S_FULL  ? (pop ? S_FETCH : S_FULL) :
                        (credit ? S_FETCH : S_FULL);
            inflight <= imem_rd;
            if (imem_rd) begin
                tag      <= fetch_pc;
                fetch_pc <= fetch_pc + PC_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_imem_prefetch_buf.sv
// tb_imem_prefetch_buf: vector table, corner sequences and random traffic against a queue-level model
module tb_imem_prefetch_buf;
    localparam int DEPTH = 4;
`ifdef IMEM_PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic resetn = 1'b1, redirect_valid = 1'b0, inst_ready = 1'b0;
    logic [15:0] redirect_pc = '0, imem_data = '0;
    logic [15:0] imem_addr, inst, inst_pc;
    logic imem_rd, inst_valid;
    logic [2:0] occupancy;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    imem_prefetch_buf #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .imem_data      (imem_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .occupancy      (occupancy)
    );

    function automatic logic [15:0] rom(input logic [15:0] a);
        return 16'hA000 + a;
    endfunction

    // reference model: fetched words waiting for the IR, plus one outstanding request
    typedef struct packed {logic [15:0] i; logic [15:0] p;} ent_t;
    ent_t m_q[$];
    bit m_init = 1'b0, m_fly = 1'b0;
    logic [15:0] m_pc = '0, m_tag = '0;
    int m_mode = 0;
    bit s_rd, s_v;
    logic [15:0] s_addr, s_inst, s_pc;
    int s_occ;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit v, input logic [15:0] p, input bit y);
        bit e_rd, e_v, live, take, credit, popped;
        ent_t e_h;
        resetn = r;
        redirect_valid = v;
        redirect_pc = p;
        inst_ready = y;
        @(negedge clk);
        s_rd = imem_rd;
        s_addr = imem_addr;
        s_v = inst_valid;
        s_inst = inst;
        s_pc = inst_pc;
        s_occ = int'(occupancy);
        live = m_fly && !v;
        credit = m_q.size() + int'(m_fly) < DEPTH;
        e_rd = !r && !v && m_mode == 0 && credit;
        e_v = m_q.size() > 0 || (BYP && live);
        if (m_q.size() > 0) e_h = m_q[0];
        else e_h = '{i: rom(m_tag), p: m_tag};
        take = BYP && live && m_q.size() == 0 && y;
        if (m_init) begin
            chk("m_rd", 32'(s_rd), 32'(e_rd));
            chk("m_addr", 32'(s_addr), 32'(m_pc));
            chk("m_valid", 32'(s_v), 32'(e_v));
            chk("m_occ", s_occ, m_q.size());
            if (e_v) begin
                chk("m_inst", 32'(s_inst), 32'(e_h.i));
                chk("m_pc", 32'(s_pc), 32'(e_h.p));
            end
        end
        @(posedge clk);
        popped = m_q.size() > 0 && y;
        if (r) begin
            m_init = 1'b1;
            m_q.delete();
            m_fly = 1'b0;
            m_pc = 16'h0000;
            m_mode = 0;
        end else if (v) begin
            m_q.delete();
            m_fly = 1'b0;
            m_pc = p;
            m_mode = 2;
        end else begin
            if (popped) void'(m_q.pop_front());
            if (m_fly && !take) m_q.push_back('{i: rom(m_tag), p: m_tag});
            m_mode = m_mode == 2 ? 0 : m_mode == 1 ? (popped ? 0 : 1) : (credit ? 0 : 1);
            if (e_rd) begin
                m_tag = m_pc;
                m_pc = m_pc + 16'd1;
            end
            m_fly = e_rd;
        end
        #1;
        imem_data = s_rd ? rom(s_addr) : 16'($urandom);
    endtask

    typedef struct {
        bit r; bit v; logic [15:0] p; bit y;
        bit rd; logic [15:0] addr; bit val; logic [15:0] pc; int occ;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t mk(input bit r, input bit v, input logic [15:0] p, input bit y,
                                input bit rd, input logic [15:0] addr, input bit val,
                                input logic [15:0] pc, input int occ);
        vec_t t;
        t.r = r; t.v = v; t.p = p; t.y = y;
        t.rd = rd; t.addr = addr; t.val = val; t.pc = pc; t.occ = occ;
        return t;
    endfunction

    initial begin
        bit r, v, y;
        logic [15:0] p;
        // reset, then free-running fetch with the IR always ready
        vt.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 0));
        vt.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0000, 0, 16'h0000, 0));
        vt.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0001, 0, 16'h0000, 0));
        vt.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0002, 1, 16'h0000, 1));
        vt.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0003, 1, 16'h0001, 1));
        vt.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0004, 1, 16'h0002, 1));
        // reset in the middle of a fetch, then fill with the IR stalled
        vt.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0005, 1, 16'h0003, 1));
        vt.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0));
        vt.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 0));
        vt.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0001, 0, 16'h0000, 0));
        vt.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0002, 1, 16'h0000, 1));
        vt.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0003, 1, 16'h0000, 2));
        vt.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0004, 1, 16'h0000, 3));
        vt.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0004, 1, 16'h0000, 4));
        vt.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0004, 1, 16'h0000, 4));
        vt.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0004, 1, 16'h0001, 3));
        vt.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0005, 1, 16'h0001, 3));
        vt.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0005, 1, 16'h0001, 4));
        vt.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0005, 1, 16'h0001, 4));
        vt.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0005, 1, 16'h0002, 3));
        // redirect while addr 5 is in flight: bubble, then refetch at 0100
        vt.push_back(mk(0, 1, 16'h0100, 0, 0, 16'h0006, 1, 16'h0002, 3));
        vt.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0100, 0, 16'h0000, 0));
        vt.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0100, 0, 16'h0000, 0));
        vt.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0101, 0, 16'h0000, 0));
        vt.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0102, 1, 16'h0100, 1));
        vt.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0103, 1, 16'h0100, 2));
        // redirect plus pop with three queued, target wraps through FFFF
        vt.push_back(mk(0, 1, 16'hFFFE, 1, 0, 16'h0104, 1, 16'h0100, 3));
        vt.push_back(mk(0, 0, 16'h0000, 1, 0, 16'hFFFE, 0, 16'h0000, 0));
        vt.push_back(mk(0, 0, 16'h0000, 1, 1, 16'hFFFE, 0, 16'h0000, 0));
        vt.push_back(mk(0, 0, 16'h0000, 1, 1, 16'hFFFF, 0, 16'h0000, 0));
        vt.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0000, 1, 16'hFFFE, 1));
        vt.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0001, 1, 16'hFFFF, 1));
        vt.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0002, 1, 16'h0000, 1));
        vt.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0003, 1, 16'h0001, 1));

        cyc(1, 0, 16'h0000, 1);
`ifndef IMEM_PREFETCH_BYPASS_EN
        foreach (vt[k]) begin
            cyc(vt[k].r, vt[k].v, vt[k].p, vt[k].y);
            chk($sformatf("t_rd[%0d]", k), 32'(s_rd), 32'(vt[k].rd));
            chk($sformatf("t_addr[%0d]", k), 32'(s_addr), 32'(vt[k].addr));
            chk($sformatf("t_valid[%0d]", k), 32'(s_v), 32'(vt[k].val));
            chk($sformatf("t_occ[%0d]", k), s_occ, vt[k].occ);
            if (vt[k].val || vt[k].r) begin
                chk($sformatf("t_pc[%0d]", k), 32'(s_pc), vt[k].val ? 32'(vt[k].pc) : 32'h0);
                chk($sformatf("t_inst[%0d]", k), 32'(s_inst), vt[k].val ? 32'(rom(vt[k].pc)) : 32'h0);
            end
        end
`else
        // empty queue, IR ready: the word is delivered in the cycle it returns
        cyc(1, 0, 16'h0000, 1);
        cyc(0, 0, 16'h0000, 1);
        chk("b_rd", 32'(s_rd), 32'h1);
        chk("b_valid0", 32'(s_v), 32'h0);
        cyc(0, 0, 16'h0000, 1);
        chk("b_valid1", 32'(s_v), 32'h1);
        chk("b_inst1", 32'(s_inst), 32'hA000);
        chk("b_pc1", 32'(s_pc), 32'h0000);
        chk("b_occ1", s_occ, 0);
        cyc(0, 0, 16'h0000, 1);
        chk("b_valid2", 32'(s_v), 32'h1);
        chk("b_pc2", 32'(s_pc), 32'h0001);
        chk("b_occ2", s_occ, 0);
`endif
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom % 100) == 0;
            v = ($urandom % 12) == 0;
            p = ($urandom % 4 == 0) ? 16'hFFFC + 16'($urandom % 4) : 16'($urandom);
            y = ($urandom % 10) < 6;
            cyc(r, v, p, y);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
